// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: operand-fetch/decode stage feeding the ALU.
// Decodes 32-bit instruction words, reads a NREGS x DW register file and
// presents registered in1/in2/func/out_rd behind a one-deep valid/ready slot.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-back forwarded into
// operand reads; default build reads the old register value).
module alu_operand_fetch #(
   parameter int NREGS = 16,
   parameter int DW    = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ins_valid,
   output logic          ins_ready,
   input  logic [31:0]   ins,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] in1,
   output logic [DW-1:0] in2,
   output logic [3:0]    func,
   output logic [AW-1:0] out_rd,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic          illegal,
   output logic [15:0]   ins_count
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   localparam logic [3:0] FUNC_MAX = 4'b1000;

   logic [DW-1:0] rf_q [NREGS];

   logic [0:0]    state_q, state_d;
   logic [DW-1:0] in1_q, in1_d;
   logic [DW-1:0] in2_q, in2_d;
   logic [3:0]    func_q, func_d;
   logic [AW-1:0] rd_q, rd_d;
   logic          illegal_q;
   logic [15:0]   count_q;

   // Instruction field decode
   logic [3:0]    dec_func;
   logic          dec_use_imm;
   logic [AW-1:0] dec_rs, dec_rt, dec_rd;
   logic [14:0]   dec_imm;
   logic [DW-1:0] imm_ext;
   logic [DW-1:0] rs_val, rt_val;
   logic          accept, legal, issue;

   assign dec_func    = ins[31:28];
   assign dec_use_imm = ins[27];
   assign dec_rs      = ins[26:23];
   assign dec_rt      = ins[22:19];
   assign dec_rd      = ins[18:15];
   assign dec_imm     = ins[14:0];
   assign imm_ext     = {{(DW-15){dec_imm[14]}}, dec_imm};

   assign out_valid = (state_q == FULL);
   assign ins_ready = !out_valid || out_ready;
   assign accept    = ins_valid && ins_ready;
   assign legal     = (dec_func <= FUNC_MAX);
   assign issue     = out_valid && out_ready;

   // Register-file read ports; R0 is hardwired to zero
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (dec_rs != '0) begin
         rs_val = rf_q[dec_rs];
`ifdef RF_BYPASS_EN
         if (wb_en && (wb_addr == dec_rs)) rs_val = wb_data;
`endif
      end
      if (dec_rt != '0) begin
         rt_val = rf_q[dec_rt];
`ifdef RF_BYPASS_EN
         if (wb_en && (wb_addr == dec_rt)) rt_val = wb_data;
`endif
      end
   end

   // Next-state for the output slot: load on legal accept, drain on consume, else hold
   always_comb begin
      state_d = state_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      func_d  = func_q;
      rd_d    = rd_q;
      if (accept && legal) begin
         state_d = FULL;
         in1_d   = rs_val;
         in2_d   = dec_use_imm ? imm_ext : rt_val;
         func_d  = dec_func;
         rd_d    = dec_rd;
      end else if (out_ready) begin
         // an illegal word accepted here also implies the held word was consumed
         state_d = EMPTY;
      end
   end

   // Output slot registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         in1_q   <= '0;
         in2_q   <= '0;
         func_q  <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         func_q  <= func_d;
         rd_q    <= rd_d;
      end
   end

   // Register file write-back, independent of the handshake; R0 writes dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   // Illegal-function pulse and issued-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         illegal_q <= accept && !legal;
         if (issue) count_q <= count_q + 16'd1;
      end
   end

   assign in1       = in1_q;
   assign in2       = in2_q;
   assign func      = func_q;
   assign out_rd    = rd_q;
   assign illegal   = illegal_q;
   assign ins_count = count_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed-vector bench for alu_operand_fetch; expected values written by hand.
module tb_alu_operand_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] in1, in2;
   logic [3:0]  func;
   logic [3:0]  out_rd;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic        illegal;
   logic [15:0] ins_count;

   int unsigned pass_cnt = 0;
   int unsigned tot_cnt  = 0;
   logic [15:0] exp_cnt  = 16'd0;

   alu_operand_fetch #(.NREGS(16), .DW(32)) dut (
      .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
      .out_valid(out_valid), .out_ready(out_ready), .in1(in1), .in2(in2), .func(func),
      .out_rd(out_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .illegal(illegal), .ins_count(ins_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [3:0] f, input logic ui, input logic [3:0] rs,
                                      input logic [3:0] rt, input logic [3:0] rd, input logic [14:0] imm);
      return {f, ui, rs, rt, rd, imm};
   endfunction

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ins_valid = 1'b1; ins = mk(4'h0, 1'b0, 4'd1, 4'd2, 4'd3, 15'd0);
      out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      tick; tick;
      tot_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
      tot_cnt++; if (ins_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", ins_count); else pass_cnt++;
      tot_cnt++; if ({in1, in2, func, out_rd, illegal} !== '0)
         $display("FAIL reset_outputs got in1=%h in2=%h func=%h rd=%h ill=%b exp all 0", in1, in2, func, out_rd, illegal);
      else pass_cnt++;
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         ins = mk(4'h1, 1'b0, 4'(i), 4'(i), 4'(i), 15'd0);
         tick;
         if (i > 1) exp_cnt++;
         tot_cnt++; if (in1 !== 32'd0 || in2 !== 32'd0 || out_rd !== 4'(i) || out_valid !== 1'b1)
            $display("FAIL reset_rf_R%0d got in1=%h in2=%h rd=%0d v=%b exp 0 0 %0d 1", i, in1, in2, out_rd, out_valid, i);
         else pass_cnt++;
      end
      ins_valid = 1'b0;
      tick; exp_cnt++;
      tot_cnt++; if (ins_count !== exp_cnt || out_valid !== 1'b0)
         $display("FAIL reset_drain got cnt=%0d v=%b exp cnt=%0d v=0", ins_count, out_valid, exp_cnt);
      else pass_cnt++;
   endtask

   task automatic test_basic;
      wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'd10; tick;
      wb_addr = 4'd2; wb_data = 32'd6; tick;
      wb_en = 1'b0;
      ins_valid = 1'b1; ins = mk(4'h0, 1'b0, 4'd1, 4'd2, 4'd3, 15'd0); out_ready = 1'b1;
      tick; ins_valid = 1'b0;
      tot_cnt++; if (in1 !== 32'd10 || in2 !== 32'd6 || func !== 4'h0 || out_rd !== 4'd3 || out_valid !== 1'b1)
         $display("FAIL basic_issue got in1=%0d in2=%0d func=%h rd=%0d v=%b exp 10 6 0 3 1", in1, in2, func, out_rd, out_valid);
      else pass_cnt++;
      tick; exp_cnt++;
      tot_cnt++; if (ins_count !== exp_cnt) $display("FAIL basic_count got %0d exp %0d", ins_count, exp_cnt); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      ins_valid = 1'b1; ins = mk(4'h2, 1'b0, 4'd1, 4'd2, 4'd4, 15'd0); out_ready = 1'b0;
      tick;
      tot_cnt++; if (out_valid !== 1'b1 || in1 !== 32'd10 || ins_ready !== 1'b0)
         $display("FAIL stall_load got v=%b in1=%0d rdy=%b exp 1 10 0", out_valid, in1, ins_ready);
      else pass_cnt++;
      ins = mk(4'h7, 1'b0, 4'd2, 4'd2, 4'd9, 15'd0);
      wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'd99;
      tick; wb_en = 1'b0;
      tot_cnt++; if (in1 !== 32'd10 || in2 !== 32'd6 || func !== 4'h2 || out_rd !== 4'd4 || out_valid !== 1'b1)
         $display("FAIL stall_hold1 got in1=%0d in2=%0d func=%h rd=%0d v=%b exp 10 6 2 4 1", in1, in2, func, out_rd, out_valid);
      else pass_cnt++;
      tick;
      tot_cnt++; if (in1 !== 32'd10 || out_rd !== 4'd4 || ins_count !== exp_cnt || ins_ready !== 1'b0)
         $display("FAIL stall_hold2 got in1=%0d rd=%0d cnt=%0d rdy=%b exp 10 4 %0d 0", in1, out_rd, ins_count, ins_ready, exp_cnt);
      else pass_cnt++;
      out_ready = 1'b1; ins = mk(4'h3, 1'b0, 4'd1, 4'd2, 4'd5, 15'd0);
      #1;
      tot_cnt++; if (ins_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", ins_ready); else pass_cnt++;
      tick; exp_cnt++; ins_valid = 1'b0;
      tot_cnt++; if (in1 !== 32'd99 || in2 !== 32'd6 || func !== 4'h3 || out_rd !== 4'd5 || out_valid !== 1'b1 || ins_count !== exp_cnt)
         $display("FAIL b2b_issue got in1=%0d in2=%0d func=%h rd=%0d v=%b cnt=%0d exp 99 6 3 5 1 %0d",
                  in1, in2, func, out_rd, out_valid, ins_count, exp_cnt);
      else pass_cnt++;
      tick; exp_cnt++;
      tot_cnt++; if (out_valid !== 1'b0 || ins_count !== exp_cnt)
         $display("FAIL b2b_drain got v=%b cnt=%0d exp 0 %0d", out_valid, ins_count, exp_cnt);
      else pass_cnt++;
   endtask

   task automatic test_imm;
      ins_valid = 1'b1; out_ready = 1'b1; ins = mk(4'h0, 1'b1, 4'd2, 4'd1, 4'd6, 15'h7FFF);
      tick;
      tot_cnt++; if (in2 !== 32'hFFFF_FFFF || in1 !== 32'd6)
         $display("FAIL imm_neg got in1=%h in2=%h exp 00000006 ffffffff", in1, in2);
      else pass_cnt++;
      ins = mk(4'h8, 1'b1, 4'd2, 4'd1, 4'd7, 15'd6);
      tick; exp_cnt++; ins_valid = 1'b0;
      tot_cnt++; if (in2 !== 32'd6 || func !== 4'h8 || out_rd !== 4'd7)
         $display("FAIL imm_pos got in2=%h func=%h rd=%0d exp 00000006 8 7", in2, func, out_rd);
      else pass_cnt++;
      tick; exp_cnt++;
   endtask

   task automatic test_illegal;
      ins_valid = 1'b1; out_ready = 1'b1; ins = mk(4'hB, 1'b0, 4'd1, 4'd2, 4'd3, 15'd0);
      tick; ins_valid = 1'b0;
      tot_cnt++; if (illegal !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL illegal_pulse got ill=%b v=%b exp 1 0", illegal, out_valid);
      else pass_cnt++;
      tick;
      tot_cnt++; if (illegal !== 1'b0 || out_valid !== 1'b0 || ins_count !== exp_cnt)
         $display("FAIL illegal_after got ill=%b v=%b cnt=%0d exp 0 0 %0d", illegal, out_valid, ins_count, exp_cnt);
      else pass_cnt++;
   endtask

   task automatic test_bypass;
      logic [31:0] exp_r5;
`ifdef RF_BYPASS_EN
      exp_r5 = 32'd21;
`else
      exp_r5 = 32'd0;
`endif
      ins_valid = 1'b1; out_ready = 1'b1; ins = mk(4'h0, 1'b0, 4'd5, 4'd5, 4'd8, 15'd0);
      wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'd21;
      tick;
      tot_cnt++; if (in1 !== exp_r5 || in2 !== exp_r5)
         $display("FAIL bypass_r5 got in1=%0d in2=%0d exp %0d %0d", in1, in2, exp_r5, exp_r5);
      else pass_cnt++;
      ins = mk(4'h0, 1'b0, 4'd0, 4'd5, 4'd8, 15'd0);
      wb_addr = 4'd0; wb_data = 32'd7;
      tick; exp_cnt++; wb_en = 1'b0;
      tot_cnt++; if (in1 !== 32'd0 || in2 !== 32'd21)
         $display("FAIL bypass_r0 got in1=%0d in2=%0d exp 0 21", in1, in2);
      else pass_cnt++;
      ins = mk(4'h0, 1'b0, 4'd0, 4'd0, 4'd1, 15'd0);
      tick; exp_cnt++; ins_valid = 1'b0;
      tot_cnt++; if (in1 !== 32'd0 || in2 !== 32'd0)
         $display("FAIL r0_nowrite got in1=%0d in2=%0d exp 0 0", in1, in2);
      else pass_cnt++;
      tick; exp_cnt++;
      tot_cnt++; if (ins_count !== exp_cnt) $display("FAIL bypass_count got %0d exp %0d", ins_count, exp_cnt); else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall;
      ins_valid = 1'b1; out_ready = 1'b0; ins = mk(4'h4, 1'b0, 4'd1, 4'd5, 4'd2, 15'd0);
      tick; ins_valid = 1'b0;
      tot_cnt++; if (out_valid !== 1'b1 || in1 !== 32'd99)
         $display("FAIL mid_stall_load got v=%b in1=%0d exp 1 99", out_valid, in1);
      else pass_cnt++;
      rst = 1'b1; ins_valid = 1'b1; wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'd55;
      tick;
      rst = 1'b0; ins_valid = 1'b0; wb_en = 1'b0; exp_cnt = 16'd0;
      tot_cnt++; if (out_valid !== 1'b0 || in1 !== 32'd0 || func !== 4'h0 || ins_count !== 16'd0)
         $display("FAIL mid_stall_rst got v=%b in1=%0d func=%h cnt=%0d exp 0 0 0 0", out_valid, in1, func, ins_count);
      else pass_cnt++;
      ins_valid = 1'b1; out_ready = 1'b1; ins = mk(4'h0, 1'b0, 4'd1, 4'd3, 4'd1, 15'd0);
      tick; ins_valid = 1'b0;
      tot_cnt++; if (in1 !== 32'd0 || in2 !== 32'd0 || out_valid !== 1'b1)
         $display("FAIL mid_stall_rf got in1=%0d in2=%0d v=%b exp 0 0 1", in1, in2, out_valid);
      else pass_cnt++;
      tick;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_imm;
      test_illegal;
      test_bypass;
      test_reset_mid_stall;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
